gen_reg_arbiter: RTL and testbench

- Round-robin arbiter and access sequencer for the wbit1-based register bank in gen.
- Shares the bank's single write/read port between NUM_REQ requesters: one-hot regSelect enable, active-low wrb strobe, din/rdout data paths.
- Runs one complete register transaction at a time, then returns a one-cycle ack with read data.

---
 rtl/gen_reg_pkg.sv | 26 ++
 rtl/rr_pick.sv | 37 +++
 rtl/gen_reg_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_gen_reg_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/gen_reg_pkg.sv
// ----------------------------------------------------------------------------
// gen_reg_pkg: state encoding, default widths and index helper for the
// register-bank arbiter.  Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package gen_reg_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam int DEF_BUS_WIDTH = 15;
  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_NUM_REGS  = 31;
  localparam int DEF_ADDR_W    = 5;

  // Operands are always below 2*n, so one conditional subtract is a full modulo.
  function automatic int wrap_idx(input int v, input int n);
    return (v >= n) ? (v - n) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick: combinational round-robin search for the first set request at or
// above rr_ptr, wrapping modulo NUM_REQ.  Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_pick
  import gen_reg_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = $clog2(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest offset down so the nearest match is written last.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = IDX_W'(wrap_idx(int'(rr_ptr_i) + off, NUM_REQ));
      if (req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/gen_reg_arbiter.sv
// ----------------------------------------------------------------------------
// gen_reg_arbiter: round-robin arbiter and access sequencer sharing the
// register bank's single write/read port.  Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module gen_reg_arbiter
  import gen_reg_pkg::*;
#(
  parameter int bus_width = DEF_BUS_WIDTH,
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic                           sysclk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]      req_addr,
  input  logic [NUM_REQ*(bus_width+1)-1:0] req_wdata,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             ack,
  output logic                           err,
  output logic [bus_width:0]             rdata,
  output logic [NUM_REGS-1:0]            regSelect,
  output logic                           wrb,
  output logic [bus_width:0]             din,
  input  logic [bus_width:0]             rdout,
  output logic                           busy
);

  localparam int DW    = bus_width + 1;
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [1:0]          state_q,  state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    idx_q,    idx_d;
  logic                we_q,     we_d;
  logic [ADDR_W-1:0]   addr_q,   addr_d;
  logic [NUM_REQ-1:0]  gnt_q,    gnt_d;
  logic [NUM_REQ-1:0]  ack_q,    ack_d;
  logic                err_q,    err_d;
  logic [DW-1:0]       rdata_q,  rdata_d;
  logic [DW-1:0]       din_q,    din_d;
  logic [NUM_REGS-1:0] regsel_q, regsel_d;
  logic                wrb_q,    wrb_d;

  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_we;
  logic [ADDR_W-1:0]   pick_addr;
  logic [DW-1:0]       pick_wdata;
  logic                pick_legal;
  logic [NUM_REGS-1:0] pick_onehot;
  logic [NUM_REQ-1:0]  pick_gnt;
  logic                cur_legal;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .valid_o  (pick_valid),
    .idx_o    (pick_idx)
  );

  always_comb begin
    pick_we    = 1'b0;
    pick_addr  = '0;
    pick_wdata = '0;
    pick_gnt   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        pick_we     = req_we[i];
        pick_addr   = req_addr[i*ADDR_W +: ADDR_W];
        pick_wdata  = req_wdata[i*DW +: DW];
        pick_gnt[i] = 1'b1;
      end
    end
  end

  assign pick_legal = (int'(pick_addr) < NUM_REGS);
  assign cur_legal  = (int'(addr_q) < NUM_REGS);

  always_comb begin
    pick_onehot = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      pick_onehot[r] = pick_legal && (int'(pick_addr) == r);
    end
  end

  // Bank-facing outputs are registered and loaded one state early so they are
  // already stable for the whole of the state that needs them.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = idx_q;
    we_d     = we_q;
    addr_d   = addr_q;
    gnt_d    = gnt_q;
    ack_d    = ack_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    din_d    = din_q;
    regsel_d = regsel_q;
    wrb_d    = wrb_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          idx_d    = pick_idx;
          we_d     = pick_we;
          addr_d   = pick_addr;
          din_d    = pick_wdata;
          gnt_d    = pick_gnt;
          regsel_d = pick_onehot;
          wrb_d    = 1'b1;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        wrb_d   = ~(we_q && cur_legal);
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        wrb_d    = 1'b1;
        regsel_d = '0;
        gnt_d    = '0;
        ack_d    = gnt_q;
        err_d    = ~cur_legal;
        if (!we_q && cur_legal) begin
          rdata_d = rdout;
        end
        rr_ptr_d = IDX_W'(wrap_idx(int'(idx_q) + 1, NUM_REQ));
        state_d  = ST_DONE;
      end
      default: begin
        ack_d   = '0;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      idx_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      din_q    <= '0;
      regsel_q <= '0;
      wrb_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      din_q    <= din_d;
      regsel_q <= regsel_d;
      wrb_q    <= wrb_d;
    end
  end

  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign regSelect = regsel_q;
  assign wrb       = wrb_q;
  assign din       = din_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_gen_reg_arbiter.sv
// ----------------------------------------------------------------------------
// tb_gen_reg_arbiter: directed self-checking bench for gen_reg_arbiter.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_gen_reg_arbiter;

  logic        sysclk;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  req_we;
  logic [19:0] req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        err;
  logic [15:0] rdata;
  logic [30:0] regSelect;
  logic        wrb;
  logic [15:0] din;
  logic [15:0] rdout;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  gen_reg_arbiter dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .ack       (ack),
    .err       (err),
    .rdata     (rdata),
    .regSelect (regSelect),
    .wrb       (wrb),
    .din       (din),
    .rdout     (rdout),
    .busy      (busy)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic we, input logic [4:0] a, input logic [15:0] d);
    req_we[i]          = we;
    req_addr[i*5 +: 5] = a;
    req_wdata[i*16 +: 16] = d;
    req[i]             = 1'b1;
  endtask

  initial begin
    reset = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0; rdout = '0;
    repeat (2) @(negedge sysclk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_regsel", 32'(regSelect), 32'h0);
    chk("rst_din", 32'(din), 32'h0);
    chk("rst_wrb", 32'(wrb), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    reset = 1'b1;
    @(negedge sysclk);

    // single write: requester 0, addr 3, 0xA5A5
    set_req(0, 1'b1, 5'd3, 16'hA5A5);
    @(negedge sysclk);
    chk("wr_setup_gnt", 32'(gnt), 32'h1);
    chk("wr_setup_regsel", 32'(regSelect), 32'h8);
    chk("wr_setup_wrb", 32'(wrb), 32'h1);
    chk("wr_setup_din", 32'(din), 32'hA5A5);
    chk("wr_setup_busy", 32'(busy), 32'h1);
    @(negedge sysclk);
    chk("wr_strobe_regsel", 32'(regSelect), 32'h8);
    chk("wr_strobe_wrb", 32'(wrb), 32'h0);
    chk("wr_strobe_ack", 32'(ack), 32'h0);
    @(negedge sysclk);
    chk("wr_done_ack", 32'(ack), 32'h1);
    chk("wr_done_err", 32'(err), 32'h0);
    chk("wr_done_wrb", 32'(wrb), 32'h1);
    chk("wr_done_regsel", 32'(regSelect), 32'h0);
    chk("wr_done_gnt", 32'(gnt), 32'h0);
    req = '0;
    @(negedge sysclk);
    chk("wr_idle_ack", 32'(ack), 32'h0);
    chk("wr_idle_busy", 32'(busy), 32'h0);

    // read-back: requester 2 reads addr 3
    rdout = 16'hA5A5;
    set_req(2, 1'b0, 5'd3, 16'h0000);
    @(negedge sysclk);
    chk("rd_setup_gnt", 32'(gnt), 32'h4);
    chk("rd_setup_wrb", 32'(wrb), 32'h1);
    @(negedge sysclk);
    chk("rd_strobe_wrb", 32'(wrb), 32'h1);
    chk("rd_strobe_regsel", 32'(regSelect), 32'h8);
    @(negedge sysclk);
    chk("rd_done_ack", 32'(ack), 32'h4);
    chk("rd_done_rdata", 32'(rdata), 32'hA5A5);
    chk("rd_done_err", 32'(err), 32'h0);
    req = '0;
    rdout = 16'h1234;
    @(negedge sysclk);
    chk("rd_hold_rdata", 32'(rdata), 32'hA5A5);
    chk("rd_idle_ack", 32'(ack), 32'h0);

    // illegal address: requester 1 reads addr 31
    set_req(1, 1'b0, 5'd31, 16'h0000);
    @(negedge sysclk);
    chk("ill_setup_gnt", 32'(gnt), 32'h2);
    chk("ill_setup_regsel", 32'(regSelect), 32'h0);
    chk("ill_setup_wrb", 32'(wrb), 32'h1);
    @(negedge sysclk);
    chk("ill_strobe_regsel", 32'(regSelect), 32'h0);
    chk("ill_strobe_wrb", 32'(wrb), 32'h1);
    @(negedge sysclk);
    chk("ill_done_ack", 32'(ack), 32'h2);
    chk("ill_done_err", 32'(err), 32'h1);
    chk("ill_done_rdata", 32'(rdata), 32'hA5A5);
    req = '0;
    @(negedge sysclk);
    chk("ill_idle_err", 32'(err), 32'h0);
    chk("ill_idle_ack", 32'(ack), 32'h0);

    // reset during STROBE of a write by requester 2 (rr_ptr is 2 here)
    set_req(2, 1'b1, 5'd5, 16'h5A5A);
    @(negedge sysclk);
    chk("rst_op_setup_gnt", 32'(gnt), 32'h4);
    chk("rst_op_setup_regsel", 32'(regSelect), 32'h20);
    @(negedge sysclk);
    chk("rst_op_strobe_wrb", 32'(wrb), 32'h0);
    reset = 1'b0;
    #1;
    chk("rst_op_async_wrb", 32'(wrb), 32'h1);
    chk("rst_op_async_regsel", 32'(regSelect), 32'h0);
    chk("rst_op_async_gnt", 32'(gnt), 32'h0);
    chk("rst_op_async_busy", 32'(busy), 32'h0);
    req = '0;
    @(negedge sysclk);
    chk("rst_op_no_ack", 32'(ack), 32'h0);
    reset = 1'b1;
    @(negedge sysclk);
    chk("rst_op_rel_busy", 32'(busy), 32'h0);
    chk("rst_op_rel_ack", 32'(ack), 32'h0);

    // contention: all four held, first grant proves rr_ptr was cleared
    req_we   = 4'b0000;
    req_addr = {5'd3, 5'd2, 5'd1, 5'd0};
    req      = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge sysclk);
      chk("cont_gnt", 32'(gnt), 32'(4'b0001 << (k % 4)));
      @(negedge sysclk);
      @(negedge sysclk);
      chk("cont_ack", 32'(ack), 32'(4'b0001 << (k % 4)));
      if (k == 4) req = '0;
      @(negedge sysclk);
      chk("cont_idle_ack", 32'(ack), 32'h0);
      chk("cont_idle_busy", 32'(busy), 32'h0);
    end

    // withdrawal: requester 3 drops req one cycle after grant
    set_req(3, 1'b1, 5'd7, 16'h0F0F);
    @(negedge sysclk);
    chk("wd_setup_gnt", 32'(gnt), 32'h8);
    req[3] = 1'b0;
    @(negedge sysclk);
    chk("wd_strobe_wrb", 32'(wrb), 32'h0);
    chk("wd_strobe_regsel", 32'(regSelect), 32'h80);
    @(negedge sysclk);
    chk("wd_done_ack", 32'(ack), 32'h8);
    @(negedge sysclk);
    chk("wd_idle_ack", 32'(ack), 32'h0);
    chk("wd_idle_busy", 32'(busy), 32'h0);
    @(negedge sysclk);
    chk("wd_no_regrant_gnt", 32'(gnt), 32'h0);
    chk("wd_no_regrant_busy", 32'(busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
